// File: rtl/regfile_operand_reader.sv
// Read-side sequencer for the thread-banked register file: fetches rs1 then rs2
// over the single registered read port, applies x0 and same-edge write bypass.
module regfile_operand_reader #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 6,
    parameter int TID_W  = 1,
    parameter int TAG_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [TID_W-1:0]  req_tid,
    input  logic [4:0]        req_rs1,
    input  logic [4:0]        req_rs2,
    input  logic [TAG_W-1:0]  req_tag,
    output logic [ADDR_W-1:0] rf_addrb,
    input  logic [DATA_W-1:0] rf_doutb,
    input  logic              wb_we,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rs1_data,
    output logic [DATA_W-1:0] rsp_rs2_data,
    output logic [TAG_W-1:0]  rsp_tag
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RD1  = 2'd1;
    localparam logic [1:0] S_RD2  = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [TID_W-1:0]  tid_q, tid_d;
    logic [4:0]        rs1_q, rs1_d;
    logic [4:0]        rs2_q, rs2_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic              byp_q, byp_d;
    logic [DATA_W-1:0] byp_data_q, byp_data_d;
    logic [DATA_W-1:0] op1_q, op1_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rs1_q, rsp_rs1_d;
    logic [DATA_W-1:0] rsp_rs2_q, rsp_rs2_d;
    logic [TAG_W-1:0]  rsp_tag_q, rsp_tag_d;

    always_comb begin
        state_d     = state_q;
        tid_d       = tid_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        tag_d       = tag_q;
        byp_d       = byp_q;
        byp_data_d  = byp_data_q;
        op1_d       = op1_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rs1_d   = rsp_rs1_q;
        rsp_rs2_d   = rsp_rs2_q;
        rsp_tag_d   = rsp_tag_q;

        req_ready = (state_q == S_IDLE) && !rst;
        if ((state_q == S_RD1) || (state_q == S_RD2)) begin
            rf_addrb = {tid_q, rs2_q};
        end else begin
            rf_addrb = {req_tid, req_rs1};
        end

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    tid_d      = req_tid;
                    rs1_d      = req_rs1;
                    rs2_d      = req_rs2;
                    tag_d      = req_tag;
                    byp_d      = wb_we && (wb_addr == {req_tid, req_rs1});
                    byp_data_d = wb_data;
                    state_d    = S_RD1;
                end
            end
            S_RD1: begin
                // The bypass flag/data pair is reused: rs1's snapshot is consumed here,
                // then overwritten with the rs2 snoop taken at this same edge.
                if (rs1_q == 5'd0) begin
                    op1_d = '0;
                end else if (byp_q) begin
                    op1_d = byp_data_q;
                end else begin
                    op1_d = rf_doutb;
                end
                byp_d      = wb_we && (wb_addr == {tid_q, rs2_q});
                byp_data_d = wb_data;
                state_d    = S_RD2;
            end
            S_RD2: begin
                if (rs2_q == 5'd0) begin
                    rsp_rs2_d = '0;
                end else if (byp_q) begin
                    rsp_rs2_d = byp_data_q;
                end else begin
                    rsp_rs2_d = rf_doutb;
                end
                rsp_rs1_d   = op1_q;
                rsp_tag_d   = tag_q;
                rsp_valid_d = 1'b1;
                state_d     = S_RESP;
            end
            default: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            tid_q       <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            tag_q       <= '0;
            byp_q       <= 1'b0;
            byp_data_q  <= '0;
            op1_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rs1_q   <= '0;
            rsp_rs2_q   <= '0;
            rsp_tag_q   <= '0;
        end else begin
            state_q     <= state_d;
            tid_q       <= tid_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            tag_q       <= tag_d;
            byp_q       <= byp_d;
            byp_data_q  <= byp_data_d;
            op1_q       <= op1_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rs1_q   <= rsp_rs1_d;
            rsp_rs2_q   <= rsp_rs2_d;
            rsp_tag_q   <= rsp_tag_d;
        end
    end

    assign rsp_valid    = rsp_valid_q;
    assign rsp_rs1_data = rsp_rs1_q;
    assign rsp_rs2_data = rsp_rs2_q;
    assign rsp_tag      = rsp_tag_q;

endmodule

// File: tb/tb_regfile_operand_reader.sv
// Scoreboard bench for regfile_operand_reader with a behavioural register-file model
// (write port A, registered read-before-write port B).
module tb_regfile_operand_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [0:0]  req_tid;
    logic [4:0]  req_rs1;
    logic [4:0]  req_rs2;
    logic [3:0]  req_tag;
    logic [5:0]  rf_addrb;
    logic [63:0] rf_doutb;
    logic        wb_we;
    logic [5:0]  wb_addr;
    logic [63:0] wb_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_rs1_data;
    logic [63:0] rsp_rs2_data;
    logic [3:0]  rsp_tag;

    regfile_operand_reader #(
        .DATA_W(64),
        .ADDR_W(6),
        .TID_W (1),
        .TAG_W (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_tid     (req_tid),
        .req_rs1     (req_rs1),
        .req_rs2     (req_rs2),
        .req_tag     (req_tag),
        .rf_addrb    (rf_addrb),
        .rf_doutb    (rf_doutb),
        .wb_we       (wb_we),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rs1_data(rsp_rs1_data),
        .rsp_rs2_data(rsp_rs2_data),
        .rsp_tag     (rsp_tag)
    );

    always #5 clk = ~clk;

    logic [63:0] mem [64];
    always @(posedge clk) begin
        if (wb_we) mem[wb_addr] <= wb_data;
        rf_doutb <= mem[rf_addrb];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [63:0] o1;
        logic [63:0] o2;
        logic [3:0]  tag;
    } exp_t;
    exp_t exp_q[$];

    int n_total = 0;
    int n_pass  = 0;
    int n_push  = 0;
    int n_rsp   = 0;
    int last_accept_cyc = 0;

    localparam logic [63:0] V5 = 64'hAAAA_0000_0000_0005;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, req);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [5:0] a, input logic [63:0] d);
        wb_we = 1'b1; wb_addr = a; wb_data = d;
        tick();
        wb_we = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!req_ready && n < 50) begin
            tick();
            n++;
        end
        if (!req_ready) chk("wait_idle_timeout", 64'(req_ready), 64'd1);
    endtask

    // Returns one time unit after the accept edge, leaving the DUT in RD1.
    task automatic issue(input logic t, input logic [4:0] r1, input logic [4:0] r2,
                         input logic [3:0] tg, input logic push,
                         input logic [63:0] e1, input logic [63:0] e2, output int acc);
        exp_t e;
        wait_idle();
        req_valid = 1'b1; req_tid = t; req_rs1 = r1; req_rs2 = r2; req_tag = tg;
        @(posedge clk);
        if (push) begin
            e.o1 = e1; e.o2 = e2; e.tag = tg;
            exp_q.push_back(e);
            n_push++;
        end
        #1;
        acc = cyc;
        last_accept_cyc = cyc;
        req_valid = 1'b0;
    endtask

    // Monitor: pops the scoreboard on every response handshake.
    logic prev_valid = 1'b0;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (rsp_valid && !prev_valid) begin
                    if (exp_q.size() == 0) begin
                        n_total++;
                        $display("FAIL unexpected_rsp: got rsp_valid=1 tag=%0h, required no response", rsp_tag);
                    end else begin
                        chk("latency", 64'(cyc - last_accept_cyc), 64'd2);
                    end
                end
                if (rsp_valid && rsp_ready && exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    n_rsp++;
                    chk("rsp_op1", rsp_rs1_data, e.o1);
                    chk("rsp_op2", rsp_rs2_data, e.o2);
                    chk("rsp_tag", 64'(rsp_tag), 64'(e.tag));
                end
            end
            prev_valid = rsp_valid;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int a1, a2, ax;
        rst = 1'b1; req_valid = 1'b0; req_tid = '0; req_rs1 = '0; req_rs2 = '0; req_tag = '0;
        wb_we = 1'b0; wb_addr = '0; wb_data = '0; rsp_ready = 1'b1;
        repeat (3) tick();
        chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset_req_ready", 64'(req_ready), 64'd0);
        chk("reset_op1", rsp_rs1_data, 64'd0);
        chk("reset_op2", rsp_rs2_data, 64'd0);
        chk("reset_tag", 64'(rsp_tag), 64'd0);
        rst = 1'b0;
        #1;
        chk("idle_req_ready", 64'(req_ready), 64'd1);

        // Basic fetch and accept spacing with rsp_ready high
        wr({1'b0, 5'd5}, V5);
        wr({1'b0, 5'd6}, 64'h6);
        issue(1'b0, 5'd5, 5'd6, 4'd3, 1'b1, V5, 64'h6, a1);
        issue(1'b0, 5'd6, 5'd5, 4'd4, 1'b1, 64'h6, V5, a2);
        chk("accept_spacing", 64'(a2 - a1), 64'd4);

        // x0 reads zero despite RAM contents and a same-edge write
        wait_idle();
        wr({1'b0, 5'd0}, 64'hFFFF_FFFF_FFFF_FFFF);
        wb_we = 1'b1; wb_addr = {1'b0, 5'd0}; wb_data = 64'h1234;
        issue(1'b0, 5'd0, 5'd0, 4'd5, 1'b1, 64'd0, 64'd0, ax);
        wb_we = 1'b0;

        // rs1 same-edge bypass, then a write to the other bank must not bypass
        wait_idle();
        wr({1'b1, 5'd7}, 64'h11);
        wb_we = 1'b1; wb_addr = {1'b1, 5'd7}; wb_data = 64'h22;
        issue(1'b1, 5'd7, 5'd0, 4'd6, 1'b1, 64'h22, 64'd0, ax);
        wb_we = 1'b0;
        wait_idle();
        wr({1'b1, 5'd7}, 64'h11);
        wb_we = 1'b1; wb_addr = {1'b0, 5'd7}; wb_data = 64'h33;
        issue(1'b1, 5'd7, 5'd0, 4'd7, 1'b1, 64'h11, 64'd0, ax);
        wb_we = 1'b0;

        // rs2 bypass at E1, then the same write at E2 is not seen
        wait_idle();
        wr({1'b0, 5'd9}, 64'h90);
        issue(1'b0, 5'd5, 5'd9, 4'd8, 1'b1, V5, 64'h99, ax);
        wr({1'b0, 5'd9}, 64'h99);
        wait_idle();
        wr({1'b0, 5'd9}, 64'h90);
        issue(1'b0, 5'd5, 5'd9, 4'd9, 1'b1, V5, 64'h90, ax);
        tick();
        wr({1'b0, 5'd9}, 64'h99);

        // Backpressure: outputs hold for 10 cycles, then one handshake
        wait_idle();
        rsp_ready = 1'b0;
        issue(1'b0, 5'd6, 5'd5, 4'hA, 1'b1, 64'h6, V5, ax);
        for (int i = 0; i < 5 && !rsp_valid; i++) tick();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_rsp_valid", 64'(rsp_valid), 64'd1);
            chk("bp_op1", rsp_rs1_data, 64'h6);
            chk("bp_op2", rsp_rs2_data, V5);
            chk("bp_tag", 64'(rsp_tag), 64'hA);
            chk("bp_req_ready", 64'(req_ready), 64'd0);
        end
        tick();
        rsp_ready = 1'b1;
        tick();
        chk("bp_done_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("bp_done_req_ready", 64'(req_ready), 64'd1);

        // Reset while in RD1 drops the request and clears the outputs
        issue(1'b0, 5'd5, 5'd6, 4'hB, 1'b0, 64'd0, 64'd0, ax);
        rst = 1'b1;
        tick();
        chk("rst_mid_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_mid_req_ready", 64'(req_ready), 64'd0);
        chk("rst_mid_op1", rsp_rs1_data, 64'd0);
        chk("rst_mid_op2", rsp_rs2_data, 64'd0);
        chk("rst_mid_tag", 64'(rsp_tag), 64'd0);
        rst = 1'b0;
        #1;
        chk("rst_mid_idle", 64'(req_ready), 64'd1);
        repeat (5) tick();
        issue(1'b0, 5'd6, 5'd5, 4'hC, 1'b1, 64'h6, V5, ax);

        wait_idle();
        repeat (3) tick();
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        chk("response_count", 64'(n_rsp), 64'(n_push));
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
